// File: rtl/stack_op_sequencer.sv
// Instruction-level sequencer for the stack/ALU datapath: accepts 16-bit stack instructions,
// checks depth legality, and drives stack actions over one to three cycles per instruction.
module stack_op_sequencer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    input  logic [15:0]                  instr,
    output logic                         instr_ready,
    output logic [3:0]                   stackAction,
    output logic [2:0]                   aluCode,
    output logic [15:0]                  in_val,
    input  logic [15:0]                  top,
    input  logic [15:0]                  next,
    input  logic [15:0]                  aluResult,
    output logic                         out_valid,
    output logic [15:0]                  out_data,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         err
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

    localparam logic [3:0] OpPushi  = 4'h1;
    localparam logic [3:0] OpPop    = 4'h2;
    localparam logic [3:0] OpDup    = 4'h3;
    localparam logic [3:0] OpSwap   = 4'h4;
    localparam logic [3:0] OpAlu    = 4'h5;
    localparam logic [3:0] OpOut    = 4'h6;
    localparam logic [3:0] OpClrerr = 4'hF;

    localparam logic [3:0] ActHold    = 4'h0;
    localparam logic [3:0] ActPush    = 4'h1;
    localparam logic [3:0] ActPop     = 4'h2;
    localparam logic [3:0] ActReplace = 4'h3;

    typedef enum logic [1:0] {StIdle, StS1, StS2, StS3} state_t;

    state_t      state;
    logic [3:0]  op;
    logic [2:0]  alu;
    logic [15:0] b_val;
    logic        legal;

    assign instr_ready = (state == StIdle);

    always_comb begin
        legal = 1'b1;
        case (instr[15:12])
            OpPushi:       legal = (depth < DepthMax);
            OpPop, OpOut:  legal = (depth != '0);
            OpDup:         legal = (depth != '0) && (depth < DepthMax);
            OpSwap, OpAlu: legal = (depth > DW'(1));
            default:       legal = 1'b1;
        endcase
    end

    // Outputs are registered: each transition loads the values for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            op          <= '0;
            alu         <= '0;
            b_val       <= '0;
            stackAction <= ActHold;
            aluCode     <= '0;
            in_val      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            depth       <= '0;
            err         <= 1'b0;
        end else begin
            stackAction <= ActHold;
            in_val      <= '0;
            aluCode     <= '0;
            out_valid   <= 1'b0;
            state       <= StIdle;
            case (state)
                StIdle: begin
                    if (instr_valid) begin
                        op  <= instr[15:12];
                        alu <= instr[2:0];
                        if (!legal) begin
                            err <= 1'b1;
                        end else begin
                            state <= StS1;
                            case (instr[15:12])
                                OpPushi: begin
                                    stackAction <= ActPush;
                                    in_val      <= {4'h0, instr[11:0]};
                                end
                                OpPop:  stackAction <= ActPop;
                                OpDup: begin
                                    stackAction <= ActPush;
                                    in_val      <= top;
                                end
                                OpSwap: stackAction <= ActPop;
                                OpAlu: begin
                                    stackAction <= ActPop;
                                    aluCode     <= instr[2:0];
                                end
                                OpOut: begin
                                    out_valid <= 1'b1;
                                    out_data  <= top;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StS1: begin
                    case (op)
                        OpPushi, OpDup: depth <= depth + 1'b1;
                        OpPop:          depth <= depth - 1'b1;
                        // top/next still show the pre-pop entries on this edge
                        OpSwap: begin
                            depth       <= depth - 1'b1;
                            b_val       <= next;
                            stackAction <= ActReplace;
                            in_val      <= top;
                            state       <= StS2;
                        end
                        OpAlu: begin
                            depth       <= depth - 1'b1;
                            stackAction <= ActReplace;
                            in_val      <= aluResult;
                            aluCode     <= alu;
                            state       <= StS2;
                        end
                        OpClrerr: err <= 1'b0;
                        default: ;
                    endcase
                end
                StS2: begin
                    if (op == OpSwap) begin
                        stackAction <= ActPush;
                        in_val      <= b_val;
                        state       <= StS3;
                    end
                end
                StS3: depth <= depth + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: a behavioural stack/ALU environment, directed scenarios and
// randomized instruction streams checked against a queue-based reference model.
module tb_stack_op_sequencer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr = '0;
    logic          instr_ready;
    logic [3:0]    stackAction;
    logic [2:0]    aluCode;
    logic [15:0]   in_val;
    logic [15:0]   top, next, aluResult;
    logic          out_valid;
    logic [15:0]   out_data;
    logic [DW-1:0] depth;
    logic          err;

    int checks = 0;
    int failures = 0;

    stack_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .stackAction(stackAction), .aluCode(aluCode),
        .in_val(in_val), .top(top), .next(next), .aluResult(aluResult),
        .out_valid(out_valid), .out_data(out_data), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] c, input logic [15:0] a,
                                           input logic [15:0] b);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[3:0];
            3'd6: return ~a;
            default: return b;
        endcase
    endfunction

    // Stack memory environment, index env_cnt-1 is the top.
    logic [15:0] env_stk [16];
    int          env_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_cnt <= 0;
        end else begin
            case (stackAction)
                4'h1: if (env_cnt < 16) begin
                    env_stk[env_cnt] <= in_val;
                    env_cnt <= env_cnt + 1;
                end
                4'h2: if (env_cnt > 0) env_cnt <= env_cnt - 1;
                4'h3: if (env_cnt > 0) env_stk[env_cnt-1] <= in_val;
                default: ;
            endcase
        end
    end

    always_comb begin
        top  = (env_cnt > 0) ? env_stk[env_cnt-1] : 16'h0;
        next = (env_cnt > 1) ? env_stk[env_cnt-2] : 16'h0;
        aluResult = alu_fn(aluCode, top, next);
    end

    // Observations of one instruction's busy cycles.
    logic [3:0]  obs_act [6];
    logic [15:0] obs_val [6];
    logic [2:0]  obs_alu [6];
    logic        obs_ov  [6];
    int          obs_n;

    // Reference model: ref_q[0] is the top.
    logic [15:0] ref_q [$];
    logic        ref_err;
    logic [15:0] ref_out;
    logic [3:0]  exp_act [4];
    logic [15:0] exp_val [4];
    logic [2:0]  exp_alu [4];
    logic        exp_ov  [4];
    int          exp_n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ref_q.delete();
        ref_err = 1'b0;
        ref_out = '0;
    endtask

    // Must be called at a negedge with instr_ready high; returns at the next such negedge.
    task automatic run_instr(input logic [15:0] ins);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        obs_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (instr_ready) break;
            obs_act[k] = stackAction;
            obs_val[k] = in_val;
            obs_alu[k] = aluCode;
            obs_ov[k]  = out_valid;
            obs_n++;
        end
    endtask

    task automatic model_step(input logic [15:0] ins);
        logic [3:0]  op;
        logic [15:0] a, b;
        int          d;
        logic        legal;
        op = ins[15:12];
        d = ref_q.size();
        exp_n = 0;
        for (int i = 0; i < 4; i++) begin
            exp_act[i] = 4'h0; exp_val[i] = '0; exp_alu[i] = '0; exp_ov[i] = 1'b0;
        end
        case (op)
            4'h1:       legal = d < DEPTH;
            4'h2, 4'h6: legal = d >= 1;
            4'h3:       legal = d >= 1 && d < DEPTH;
            4'h4, 4'h5: legal = d >= 2;
            default:    legal = 1'b1;
        endcase
        if (!legal) begin
            ref_err = 1'b1;
            return;
        end
        exp_n = 1;
        case (op)
            4'h1: begin
                exp_act[0] = 4'h1; exp_val[0] = {4'h0, ins[11:0]};
                ref_q.push_front({4'h0, ins[11:0]});
            end
            4'h2: begin
                exp_act[0] = 4'h2;
                void'(ref_q.pop_front());
            end
            4'h3: begin
                exp_act[0] = 4'h1; exp_val[0] = ref_q[0];
                ref_q.push_front(ref_q[0]);
            end
            4'h4: begin
                a = ref_q[0]; b = ref_q[1];
                exp_n = 3;
                exp_act[0] = 4'h2; exp_act[1] = 4'h3; exp_act[2] = 4'h1;
                exp_val[1] = a; exp_val[2] = b;
                ref_q[0] = b; ref_q[1] = a;
            end
            4'h5: begin
                a = alu_fn(ins[2:0], ref_q[0], ref_q[1]);
                exp_n = 2;
                exp_act[0] = 4'h2; exp_act[1] = 4'h3;
                exp_val[1] = a;
                exp_alu[0] = ins[2:0]; exp_alu[1] = ins[2:0];
                void'(ref_q.pop_front());
                ref_q[0] = a;
            end
            4'h6: begin
                exp_ov[0] = 1'b1;
                ref_out = ref_q[0];
            end
            4'hF: ref_err = 1'b0;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        #3;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
        checks++; if (stackAction !== 4'h0 || aluCode !== 3'h0 || in_val !== 16'h0) begin
            failures++; $display("FAIL rst_drive got act=%h alu=%h val=%h exp=0", stackAction, aluCode, in_val); end
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
            failures++; $display("FAIL rst_out got ov=%b data=%h exp=0", out_valid, out_data); end
        checks++; if (depth !== '0 || err !== 1'b0) begin
            failures++; $display("FAIL rst_state got depth=%0d err=%b exp=0", depth, err); end
    endtask

    task automatic test_push_alu();
        do_reset();
        run_instr(16'h1005);
        checks++; if (obs_n !== 1 || obs_act[0] !== 4'h1 || obs_val[0] !== 16'h5) begin
            failures++; $display("FAIL pushi_seq got n=%0d act=%h val=%h exp n=1 act=1 val=5", obs_n, obs_act[0], obs_val[0]); end
        run_instr(16'h1003);
        checks++; if (top !== 16'h3 || next !== 16'h5 || depth !== 4'd2) begin
            failures++; $display("FAIL pushi_stack got top=%h next=%h depth=%0d exp 3 5 2", top, next, depth); end
        run_instr(16'h5000);
        checks++; if (obs_n !== 2 || obs_act[0] !== 4'h2 || obs_act[1] !== 4'h3 || obs_val[1] !== 16'h8) begin
            failures++; $display("FAIL alu_seq got n=%0d acts=%h,%h val=%h exp n=2 acts=2,3 val=8", obs_n, obs_act[0], obs_act[1], obs_val[1]); end
        checks++; if (top !== 16'h8 || depth !== 4'd1) begin
            failures++; $display("FAIL alu_result got top=%h depth=%0d exp 8 1", top, depth); end
        run_instr(16'h1004);
        run_instr(16'h5001);
        checks++; if (obs_alu[0] !== 3'h1 || obs_alu[1] !== 3'h1 || top !== 16'hFFFC) begin
            failures++; $display("FAIL alu_sub got code=%h,%h top=%h exp 1,1 fffc", obs_alu[0], obs_alu[1], top); end
    endtask

    task automatic test_swap();
        logic [11:0] sig;
        do_reset();
        run_instr(16'h1009);
        run_instr(16'h1002);
        run_instr(16'h4000);
        sig = {obs_act[0], obs_act[1], obs_act[2]};
        checks++; if (obs_n !== 3 || sig !== 12'h231) begin
            failures++; $display("FAIL swap_seq got n=%0d acts=%h exp n=3 acts=231", obs_n, sig); end
        checks++; if (top !== 16'h9 || next !== 16'h2 || depth !== 4'd2) begin
            failures++; $display("FAIL swap_stack got top=%h next=%h depth=%0d exp 9 2 2", top, next, depth); end
    endtask

    task automatic test_underflow_clrerr();
        do_reset();
        run_instr(16'h2000);
        checks++; if (obs_n !== 0 || err !== 1'b1 || depth !== '0 || stackAction !== 4'h0) begin
            failures++; $display("FAIL underflow got n=%0d err=%b depth=%0d act=%h exp 0 1 0 0", obs_n, err, depth, stackAction); end
        run_instr(16'h1007);
        checks++; if (obs_n !== 1 || err !== 1'b1 || depth !== 4'd1) begin
            failures++; $display("FAIL err_sticky got n=%0d err=%b depth=%0d exp 1 1 1", obs_n, err, depth); end
        run_instr(16'hF000);
        checks++; if (obs_n !== 1 || err !== 1'b0) begin
            failures++; $display("FAIL clrerr got n=%0d err=%b exp 1 0", obs_n, err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) run_instr(16'h1000 | 16'(i));
        run_instr(16'h1FFF);
        checks++; if (obs_n !== 0 || err !== 1'b1 || depth !== DW'(DEPTH)) begin
            failures++; $display("FAIL overflow got n=%0d err=%b depth=%0d exp 0 1 %0d", obs_n, err, depth, DEPTH); end
        run_instr(16'hF000);
        run_instr(16'h3000);
        checks++; if (obs_n !== 0 || err !== 1'b1 || depth !== DW'(DEPTH)) begin
            failures++; $display("FAIL dup_full got n=%0d err=%b depth=%0d exp 0 1 %0d", obs_n, err, depth, DEPTH); end
    endtask

    task automatic test_out_reset_mid();
        do_reset();
        run_instr(16'h10AB);
        run_instr(16'h6000);
        checks++; if (obs_n !== 1 || obs_ov[0] !== 1'b1 || out_data !== 16'h00AB || out_valid !== 1'b0) begin
            failures++; $display("FAIL out got n=%0d ov=%b data=%h ov_after=%b exp 1 1 00ab 0", obs_n, obs_ov[0], out_data, out_valid); end
        run_instr(16'h1004);
        instr_valid = 1'b1;
        instr = 16'h5000;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++; if (stackAction !== 4'h3 || in_val !== 16'h00AF) begin
            failures++; $display("FAIL alu_s2 got act=%h val=%h exp 3 00af", stackAction, in_val); end
        rst = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1 || stackAction !== 4'h0 || aluCode !== 3'h0 || in_val !== 16'h0) begin
            failures++; $display("FAIL midrst_drive got rdy=%b act=%h alu=%h val=%h exp 1 0 0 0", instr_ready, stackAction, aluCode, in_val); end
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || depth !== '0 || err !== 1'b0 || env_cnt !== 0) begin
            failures++; $display("FAIL midrst_state got ov=%b data=%h depth=%0d err=%b stk=%0d exp all 0", out_valid, out_data, depth, err, env_cnt); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_instr(16'h2000);
        run_instr(16'h4000);
        checks++; if (obs_n !== 0 || err !== 1'b1 || depth !== '0) begin
            failures++; $display("FAIL b2b_illegal got n=%0d err=%b depth=%0d exp 0 1 0", obs_n, err, depth); end
        run_instr(16'h1001);
        run_instr(16'h2000);
        run_instr(16'h1002);
        checks++; if (obs_n !== 1 || depth !== 4'd1 || top !== 16'h2) begin
            failures++; $display("FAIL pop_then_push got n=%0d depth=%0d top=%h exp 1 1 2", obs_n, depth, top); end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [3:0]  op;
        int          r;
        logic        mism;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 19);
            if (r < 5) op = 4'h1;
            else if (r < 7) op = 4'h2;
            else if (r < 9) op = 4'h3;
            else if (r < 11) op = 4'h4;
            else if (r < 13) op = 4'h5;
            else if (r < 14) op = 4'h6;
            else if (r < 15) op = 4'h0;
            else if (r < 16) op = 4'hF;
            else op = 4'($urandom_range(0, 15));
            ins = {op, 12'($urandom)};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            model_step(ins);
            run_instr(ins);
            checks++; if (obs_n !== exp_n) begin
                failures++; $display("FAIL rnd_len ins=%h got=%0d exp=%0d", ins, obs_n, exp_n);
            end else begin
                for (int i = 0; i < exp_n; i++) begin
                    checks++;
                    if (obs_act[i] !== exp_act[i] || obs_val[i] !== exp_val[i] ||
                        obs_alu[i] !== exp_alu[i] || obs_ov[i] !== exp_ov[i]) begin
                        failures++;
                        $display("FAIL rnd_cycle ins=%h cyc=%0d got act=%h val=%h alu=%h ov=%b exp act=%h val=%h alu=%h ov=%b",
                                 ins, i, obs_act[i], obs_val[i], obs_alu[i], obs_ov[i],
                                 exp_act[i], exp_val[i], exp_alu[i], exp_ov[i]);
                    end
                end
            end
            checks++; if (int'(depth) != ref_q.size() || err !== ref_err || out_data !== ref_out) begin
                failures++; $display("FAIL rnd_state ins=%h got depth=%0d err=%b out=%h exp depth=%0d err=%b out=%h",
                                     ins, depth, err, out_data, ref_q.size(), ref_err, ref_out); end
            mism = (env_cnt != ref_q.size());
            if (!mism) for (int i = 0; i < env_cnt; i++) if (env_stk[env_cnt-1-i] !== ref_q[i]) mism = 1'b1;
            checks++; if (mism) begin
                failures++; $display("FAIL rnd_stack ins=%h got cnt=%0d top=%h exp cnt=%0d", ins, env_cnt, top, ref_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_push_alu();
        test_swap();
        test_underflow_clrerr();
        test_overflow();
        test_out_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
